db_copy_master: RTL and testbench
=================================

Name: db_copy_master

Overview:
- Bus-initiator block on DATA_BUS: copies a block of 32-bit words from a source address range to a destination address range.
- Issues one read, then one write, per word, with at most one outstanding transaction.
- Sits beside the core as a second bus master, in front of the register and memory slaves on the data bus.
- Controlled by a start strobe with start/length operands; reports busy, done and error.

Parameters:
- LEN_W, 16: width of the word-count operand and of the progress counter.
- ADDR_STEP, 32'd4: byte increment applied to both addresses after each word.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- start  input  1  one-cycle request to begin a copy; sampled only in IDLE
- src_addr  input  32  first source byte address, captured on accepted start
- dst_addr  input  32  first destination byte address, captured on accepted start
- len  input  LEN_W  number of words to copy, captured on accepted start
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse at completion or abort
- error  output  1  sticky; set on bus error, cleared on next accepted start
- words_done  output  LEN_W  count of words fully written in the current or last copy
- dmst  DATA_BUS.Master  -  bus port: req, we, addr, be, wdata out; gnt, rvalid, rdata, err in

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state IDLE, busy=0, done=0, error=0, words_done=0, req=0, we=0, addr=0, be=0, wdata=0.
- Reset mid-copy returns to IDLE at that edge. No done pulse is issued; the outstanding bus response is ignored.
- Bus rules, master side:
  - A transfer is accepted at the rising edge where req=1 and gnt=1.
  - addr, we, be and wdata stay stable while req=1 and gnt=0.
  - The response arrives as rvalid one or more cycles after the grant; rdata and err are valid only with rvalid.
  - be=4'b1111 whenever req=1.
- States:
  - IDLE: req=0. On start, capture operands into src_q/dst_q/cnt_q, clear error and words_done.
    - len=0: go to FIN.
    - Otherwise go to RD_REQ.
  - RD_REQ: req=1, we=0, addr=src_q. On gnt, go to RD_WAIT.
  - RD_WAIT: req=0. On rvalid:
    - err=1: set error, go to FIN.
    - Otherwise latch rdata into data_q and go to WR_REQ.
  - WR_REQ: req=1, we=1, addr=dst_q, wdata=data_q. On gnt, go to WR_WAIT.
  - WR_WAIT: req=0. On rvalid:
    - err=1: set error, go to FIN.
    - Otherwise: words_done+1, src_q+ADDR_STEP, dst_q+ADDR_STEP, cnt_q-1.
    - If cnt_q was 1, go to FIN; else go to RD_REQ.
  - FIN: done=1 for this one cycle, busy=0 at the next edge, go to IDLE.
- busy=1 in every state except IDLE.
- start is ignored outside IDLE.
- Latency with a zero-wait slave (gnt same cycle, rvalid next cycle):
  - 4 cycles per word.
  - First req in the cycle after start.
  - done in cycle 1+4*len after start.
  - len=0: done exactly 1 cycle after start, no bus traffic.
- Address arithmetic is modulo 2^32; 0xFFFFFFFC + 4 wraps to 0x00000000. Low address bits are passed through unchanged.
- An rvalid arriving in RD_REQ or WR_REQ is impossible with a single outstanding transaction and is ignored.
- If err arrives in the same cycle as the final rvalid, the error path wins: error=1 and words_done is not incremented.

Decomposition:
- data_bus_pkg gets the copy-master state enum type and the be constant BE_WORD=4'b1111.
- config_pkg gets nothing (a master has no base/mask).
- No sub-module: a single FSM plus datapath registers.

Test Plan:
- Copy, zero-wait slave, src=0x100, dst=0x200, len=3, memory 0x100..0x108 = A,B,C -> 0x200..0x208 = A,B,C; done at cycle 13 after start; words_done=3; error=0.
- len=0 -> no req ever asserted; done pulses 1 cycle after start; busy high exactly 1 cycle.
- Slave holds gnt low 5 cycles on the first read, then rvalid delayed 3 cycles -> addr/we/be stable across the stall; data copied correctly.
- err with rvalid on the second write of len=4 -> error=1, words_done=1, done pulse, no further req; next start clears error.
- Wrap: src=0xFFFFFFFC, len=2 -> second read addr=0x00000000.
- rst asserted during WR_REQ -> next cycle req=0, busy=0, no done; start pulse after reset runs a clean copy.

Source files
------------

// File: rtl/data_bus_pkg.sv
// Shared data-bus definitions: byte-enable constant and the copy-master state type.
package data_bus_pkg;

    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [2:0] {
        CM_IDLE    = 3'd0,
        CM_RD_REQ  = 3'd1,
        CM_RD_WAIT = 3'd2,
        CM_WR_REQ  = 3'd3,
        CM_WR_WAIT = 3'd4,
        CM_FIN     = 3'd5
    } copy_state_e;

endpackage

// File: rtl/DATA_BUS.sv
// Data bus bundle: request/grant with a later rvalid response.
// Single outstanding transfer per master.
interface DATA_BUS;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    // A transfer is accepted on the edge where req and gnt are both high;
    // the master holds addr/we/be/wdata while req=1 and gnt=0, and
    // rdata/err are meaningful only in a cycle with rvalid=1.
    modport Master (output req, we, addr, be, wdata,
                    input  gnt, rvalid, rdata, err);
    modport Slave  (input  req, we, addr, be, wdata,
                    output gnt, rvalid, rdata, err);
endinterface

// File: rtl/db_copy_master.sv
// Word-copy bus master: read a word from src, write it to dst, repeat len times.
// One outstanding transaction; stops early on the first bus error.
module db_copy_master
    import data_bus_pkg::*;
#(
    parameter int          LEN_W     = 16,
    parameter logic [31:0] ADDR_STEP = 32'd4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [LEN_W-1:0] words_done,
    DATA_BUS.Master          dmst
);

    copy_state_e      state;
    copy_state_e      state_d;
    logic [31:0]      src_q;
    logic [31:0]      dst_q;
    logic [LEN_W-1:0] cnt_q;
    logic [31:0]      data_q;

    logic             req;
    logic             we;
    logic [31:0]      addr;
    logic [31:0]      wdata;

    // Bus outputs are decoded from state and the held operand registers, so
    // they stay constant for as long as a request waits for its grant.
    always_comb begin
        state_d = state;
        req     = 1'b0;
        we      = 1'b0;
        addr    = 32'd0;
        wdata   = 32'd0;
        unique case (state)
            CM_IDLE: begin
                if (start) begin
                    state_d = (len == '0) ? CM_FIN : CM_RD_REQ;
                end
            end
            CM_RD_REQ: begin
                req  = 1'b1;
                addr = src_q;
                if (dmst.gnt) state_d = CM_RD_WAIT;
            end
            CM_RD_WAIT: begin
                if (dmst.rvalid) state_d = dmst.err ? CM_FIN : CM_WR_REQ;
            end
            CM_WR_REQ: begin
                req   = 1'b1;
                we    = 1'b1;
                addr  = dst_q;
                wdata = data_q;
                if (dmst.gnt) state_d = CM_WR_WAIT;
            end
            CM_WR_WAIT: begin
                if (dmst.rvalid) begin
                    if (dmst.err || cnt_q == LEN_W'(1)) state_d = CM_FIN;
                    else                                state_d = CM_RD_REQ;
                end
            end
            CM_FIN: begin
                state_d = CM_IDLE;
            end
            default: begin
                state_d = CM_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CM_IDLE;
            src_q      <= 32'd0;
            dst_q      <= 32'd0;
            cnt_q      <= '0;
            data_q     <= 32'd0;
            error      <= 1'b0;
            words_done <= '0;
        end else begin
            state <= state_d;
            unique case (state)
                CM_IDLE: begin
                    if (start) begin
                        src_q      <= src_addr;
                        dst_q      <= dst_addr;
                        cnt_q      <= len;
                        error      <= 1'b0;
                        words_done <= '0;
                    end
                end
                CM_RD_WAIT: begin
                    if (dmst.rvalid) begin
                        if (dmst.err) error  <= 1'b1;
                        else          data_q <= dmst.rdata;
                    end
                end
                CM_WR_WAIT: begin
                    // An error on the write wins over counting the word.
                    if (dmst.rvalid) begin
                        if (dmst.err) begin
                            error <= 1'b1;
                        end else begin
                            words_done <= words_done + LEN_W'(1);
                            src_q      <= src_q + ADDR_STEP;
                            dst_q      <= dst_q + ADDR_STEP;
                            cnt_q      <= cnt_q - LEN_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy       = (state != CM_IDLE);
    assign done       = (state == CM_FIN);
    assign dmst.req   = req;
    assign dmst.we    = we;
    assign dmst.addr  = addr;
    assign dmst.wdata = wdata;
    assign dmst.be    = req ? BE_WORD : 4'b0000;

endmodule

// File: tb/tb_db_copy_master.sv
// Bench for db_copy_master: behavioural slave memory, expected-transfer scoreboard
// and completion checks against a word-level copy model.
module tb_db_copy_master;
    import data_bus_pkg::*;

    localparam int LEN_W = 16;

    // ---------------- clock / reset / DUT ----------------
    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [31:0]      src_addr;
    logic [31:0]      dst_addr;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             done;
    logic             error;
    logic [LEN_W-1:0] words_done;

    DATA_BUS dbus ();

    db_copy_master #(.LEN_W(LEN_W), .ADDR_STEP(32'd4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .words_done (words_done),
        .dmst       (dbus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [64:0] exp_q[$];   // {we, addr, wdata}; wdata is 0 for reads
    logic [32:0] done_q[$];  // {error, words_done, latency or 16'hFFFF}
    int n_cmp = 0;
    int n_bad = 0;
    int start_cyc = 0;
    int busy_cnt = 0;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- slave memory model ----------------
    logic [31:0] mem[logic [31:0]];
    int  sl_txn       = 0;
    int  sl_err_txn   = -1;
    int  sl_first_gnt = 0;
    int  sl_first_rv  = 0;
    bit  sl_random    = 1'b0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a ^ 32'hC0DE_0000) + 32'h0000_1357;
    endfunction

    // Slave drives at negedge+1: gnt after an optional stall, rvalid after a delay.
    initial begin : slave
        bit          resp_pend;
        int          resp_cnt;
        logic [31:0] resp_data;
        bit          resp_err;
        bit          wait_loaded;
        int          wait_left;
        resp_pend   = 1'b0;
        resp_cnt    = 0;
        resp_data   = 32'd0;
        resp_err    = 1'b0;
        wait_loaded = 1'b0;
        wait_left   = 0;
        dbus.gnt    = 1'b0;
        dbus.rvalid = 1'b0;
        dbus.rdata  = 32'd0;
        dbus.err    = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            dbus.gnt    = 1'b0;
            dbus.rvalid = 1'b0;
            dbus.err    = 1'b0;
            dbus.rdata  = $urandom;
            if (rst) begin
                resp_pend   = 1'b0;
                wait_loaded = 1'b0;
                continue;
            end
            if (resp_pend) begin
                if (resp_cnt == 0) begin
                    dbus.rvalid = 1'b1;
                    dbus.rdata  = resp_data;
                    dbus.err    = resp_err;
                    resp_pend   = 1'b0;
                end else begin
                    resp_cnt--;
                end
            end
            if (dbus.req && !resp_pend) begin
                if (!wait_loaded) begin
                    wait_loaded = 1'b1;
                    wait_left = sl_random ? int'($urandom_range(0, 3)) : (sl_txn == 0 ? sl_first_gnt : 0);
                end
                if (wait_left == 0) begin
                    dbus.gnt    = 1'b1;
                    wait_loaded = 1'b0;
                    resp_pend   = 1'b1;
                    resp_cnt    = sl_random ? int'($urandom_range(0, 2)) : (sl_txn == 0 ? sl_first_rv : 0);
                    resp_err    = (sl_txn == sl_err_txn);
                    if (dbus.we) begin
                        mem[dbus.addr] = dbus.wdata;
                        resp_data = $urandom;
                    end else begin
                        resp_data = mem_rd(dbus.addr);
                    end
                    sl_txn++;
                end else begin
                    wait_left--;
                end
            end
        end
    end

    // ---------------- monitor (negedge+2) ----------------
    initial begin : monitor
        logic [64:0] e;
        logic [32:0] d;
        logic [64:0] prev_bus;
        bit          prev_stall;
        prev_bus   = '0;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                prev_stall = 1'b0;
                continue;
            end
            if (busy) busy_cnt++;
            if (dbus.req) begin
                check("be_word", 65'(dbus.be), 65'(BE_WORD));
                if (prev_stall)
                    check("stall_hold", {dbus.we, dbus.addr, dbus.wdata}, prev_bus);
                if (dbus.gnt) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_req: got we=%0b addr=%h, required no transfer", dbus.we, dbus.addr);
                    end else begin
                        e = exp_q.pop_front();
                        check(e[64] ? "wr_xfer" : "rd_xfer",
                              {dbus.we, dbus.addr, e[64] ? dbus.wdata : 32'h0}, e);
                    end
                end
                prev_stall = !dbus.gnt;
                prev_bus   = {dbus.we, dbus.addr, dbus.wdata};
            end else begin
                prev_stall = 1'b0;
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got done=1, required no done pulse");
                end else begin
                    d = done_q.pop_front();
                    check("done_words", 65'(words_done), 65'(d[31:16]));
                    check("done_error", 65'(error), 65'(d[32]));
                    check("xfers_drained", 65'(exp_q.size()), 65'(0));
                    if (d[15:0] != 16'hFFFF) begin
                        check("done_latency", 65'(cyc - start_cyc), 65'(d[15:0]));
                        check("busy_cycles", 65'(busy_cnt), 65'(d[15:0]));
                    end
                end
            end
        end
    end

    // ---------------- reference model + driver tasks ----------------
    // Word-level copy model: each word is one read then one write; the
    // transfer numbered err_txn (0-based across the copy) ends it with error.
    task automatic model_copy(input logic [31:0] s, input logic [31:0] dd, input int n,
                              input int err_txn, input bit zero_wait);
        int t  = 0;
        int wd = 0;
        bit er = 1'b0;
        logic [31:0] ra;
        logic [31:0] wa;
        logic [15:0] lat;
        for (int i = 0; i < n; i++) begin
            ra = s + 32'(i) * 32'd4;
            wa = dd + 32'(i) * 32'd4;
            exp_q.push_back({1'b0, ra, 32'h0});
            if (t == err_txn) begin er = 1'b1; t++; break; end
            t++;
            exp_q.push_back({1'b1, wa, mem_rd(ra)});
            if (t == err_txn) begin er = 1'b1; t++; break; end
            t++;
            wd++;
        end
        // With an always-ready slave every transfer costs two cycles.
        lat = zero_wait ? 16'(1 + 2 * t) : 16'hFFFF;
        done_q.push_back({er, 16'(wd), lat});
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 3000; k++) begin
            if (!busy) return;
            @(negedge clk);
        end
        check("idle_timeout", 65'(busy), 65'(0));
    endtask

    task automatic start_copy(input logic [31:0] s, input logic [31:0] dd, input int n,
                              input int err_txn, input bit zero_wait, input bit poke);
        wait_idle();
        @(negedge clk);
        sl_txn     = 0;
        sl_err_txn = err_txn;
        busy_cnt   = 0;
        model_copy(s, dd, n, err_txn, zero_wait);
        start     = 1'b1;
        src_addr  = s;
        dst_addr  = dd;
        len       = LEN_W'(n);
        start_cyc = cyc;
        @(negedge clk);
        start    = 1'b0;
        src_addr = $urandom;
        dst_addr = $urandom;
        len      = LEN_W'($urandom_range(0, 9));
        if (poke && n > 0) begin
            @(negedge clk);
            start    = 1'b1;
            src_addr = 32'h3000_0000;
            len      = LEN_W'(5);
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic wait_copy();
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (done_q.size() == 0) return;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL copy_timeout: got no done, required done within 3000 cycles");
        exp_q.delete();
        done_q.delete();
    endtask

    task automatic run_copy(input logic [31:0] s, input logic [31:0] dd, input int n,
                            input int err_txn, input bit zero_wait, input bit poke);
        start_copy(s, dd, n, err_txn, zero_wait, poke);
        wait_copy();
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        bit found;
        rst      = 1'b1;
        start    = 1'b0;
        src_addr = 32'd0;
        dst_addr = 32'd0;
        len      = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              65'({busy, done, error, words_done, dbus.req, dbus.we, dbus.be}), 65'(0));
        check("reset_bus", 65'({dbus.addr, dbus.wdata}), 65'(0));
        rst = 1'b0;

        // Basic 3-word copy against an always-ready slave.
        mem[32'h100] = 32'hAAAA_0001;
        mem[32'h104] = 32'hBBBB_0002;
        mem[32'h108] = 32'hCCCC_0003;
        run_copy(32'h100, 32'h200, 3, -1, 1'b1, 1'b0);
        check("mem_200", 65'(mem_rd(32'h200)), 65'(32'hAAAA_0001));
        check("mem_204", 65'(mem_rd(32'h204)), 65'(32'hBBBB_0002));
        check("mem_208", 65'(mem_rd(32'h208)), 65'(32'hCCCC_0003));

        // Zero-length copy: done one cycle after start, no bus traffic.
        run_copy(32'h40, 32'h80, 0, -1, 1'b1, 1'b0);

        // Grant stalled 5 cycles and response delayed 3 on the first read.
        sl_first_gnt = 5;
        sl_first_rv  = 3;
        run_copy(32'h400, 32'h500, 2, -1, 1'b0, 1'b0);
        sl_first_gnt = 0;
        sl_first_rv  = 0;

        // Error on the second write, then a clean copy clears the flag.
        run_copy(32'h600, 32'h700, 4, 3, 1'b1, 1'b0);
        run_copy(32'h800, 32'h900, 1, -1, 1'b1, 1'b0);
        // Error on the very first read.
        run_copy(32'h840, 32'h940, 3, 0, 1'b1, 1'b0);

        // Address wrap on source and destination.
        run_copy(32'hFFFF_FFFC, 32'h300, 2, -1, 1'b1, 1'b0);
        run_copy(32'h0000_0C00, 32'hFFFF_FFF8, 3, -1, 1'b1, 1'b0);

        // Reset while a write request is pending.
        start_copy(32'hA00, 32'hB00, 4, -1, 1'b1, 1'b0);
        found = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (dbus.req && dbus.we) begin found = 1'b1; break; end
            @(negedge clk);
        end
        check("reach_wr_req", 65'(found), 65'(1));
        rst = 1'b1;
        exp_q.delete();
        done_q.delete();
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_copy", 65'({dbus.req, busy, done, error, words_done}), 65'(0));
        run_copy(32'hA00, 32'hB00, 4, -1, 1'b1, 1'b0);

        // Randomized copies: alternate ready slave and random-latency slave.
        for (int it = 0; it < 24; it++) begin
            int          n;
            int          et;
            logic [31:0] s;
            logic [31:0] dd;
            sl_random = (it % 2 == 1);
            n  = int'($urandom_range(0, 6));
            et = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2 * n)) : -1;
            s  = 32'h1000_0000 + 32'($urandom_range(0, 4095));
            dd = 32'h2000_0000 + 32'($urandom_range(0, 4095));
            run_copy(s, dd, n, et, !sl_random, $urandom_range(0, 1) == 1);
        end
        sl_random = 1'b0;

        repeat (3) @(negedge clk);
        check("final_queues", 65'(exp_q.size() + done_q.size()), 65'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #3_000_000;
        n_bad++;
        $display("FAIL watchdog: got simulation still running, required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
